// File: rtl/decode_serialize_ctrl_pkg.sv
// rtl/decode_serialize_ctrl_pkg.sv - shared decode defines for the serialize controller
// Purpose: core decode width, serialize FSM state type and decoded-inst record.
// Ports: none (package).
package decode_serialize_ctrl_pkg;

  localparam int DECODE_WIDTH = 4;
  localparam int DW_IDX       = $clog2(DECODE_WIDTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_CMT = 2'd2
  } serCtrlState_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] inst;
    logic        need_serialize;
  } decInfo_t;

endpackage

// File: rtl/decode_serialize_ctrl_ser_first_finder.sv
// rtl/decode_serialize_ctrl_ser_first_finder.sv - priority encoder for first serialize / first valid slot
// Purpose: finds k (lowest valid slot needing serialization) and f (lowest valid slot).
// Ports:
//   i_vld      in  per-slot valid
//   i_ser      in  per-slot need_serialize
//   o_k_oh     out one-hot of k (0 when none)
//   o_k_idx    out index of k
//   o_f_oh     out one-hot of f (0 when none)
//   o_f_idx    out index of f
//   o_below_k  out slots strictly below k (all ones when there is no k)
module ser_first_finder
  import decode_serialize_ctrl_pkg::*;
(
  input  logic [DECODE_WIDTH-1:0] i_vld,
  input  logic [DECODE_WIDTH-1:0] i_ser,
  output logic [DECODE_WIDTH-1:0] o_k_oh,
  output logic [DW_IDX-1:0]       o_k_idx,
  output logic [DECODE_WIDTH-1:0] o_f_oh,
  output logic [DW_IDX-1:0]       o_f_idx,
  output logic [DECODE_WIDTH-1:0] o_below_k
);

  logic [DECODE_WIDTH-1:0] w_cand;

  assign w_cand = i_vld & i_ser;

  always_comb begin
    o_k_oh    = '0;
    o_k_idx   = '0;
    o_f_oh    = '0;
    o_f_idx   = '0;
    // Scan high to low so the lowest hit is the last one written.
    for (int i = DECODE_WIDTH - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        o_k_oh    = '0;
        o_k_oh[i] = 1'b1;
        o_k_idx   = DW_IDX'(i);
      end
      if (i_vld[i]) begin
        o_f_oh    = '0;
        o_f_oh[i] = 1'b1;
        o_f_idx   = DW_IDX'(i);
      end
    end
    o_below_k = (|o_k_oh) ? (o_k_oh - DECODE_WIDTH'(1)) : '1;
  end

endmodule

// File: rtl/decode_serialize_ctrl.sv
// rtl/decode_serialize_ctrl.sv - decode-to-rename group register with inst serialization
// Purpose: passes decode groups to rename through one register stage; a serializing inst is
//   split off, waits for an empty backend, issues alone in slot 0, then blocks until commit.
// Optional feature: SERIALIZE_PERF_CNT_EN adds o_perf_ser_stall (cycles in DRAIN/WAIT_CMT).
// Ports:
//   clk, rst (async, active-low)
//   i_squash            backend flush
//   i_dec_vld/i_dec_info decode group; o_dec_accept consumed-slot mask (comb)
//   o_ren_vld/o_ren_info registered group to rename; i_ren_ready rename takes it
//   i_rob_empty         backend holds no insts
//   i_serialize_commit  serialized inst retired
//   o_perf_ser_stall    serialize stall cycle count (SERIALIZE_PERF_CNT_EN only)
module decode_serialize_ctrl
  import decode_serialize_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_squash,
  input  logic [DECODE_WIDTH-1:0] i_dec_vld,
  input  decInfo_t                i_dec_info [DECODE_WIDTH],
  output logic [DECODE_WIDTH-1:0] o_dec_accept,
  output logic [DECODE_WIDTH-1:0] o_ren_vld,
  output decInfo_t                o_ren_info [DECODE_WIDTH],
  input  logic                    i_ren_ready,
  input  logic                    i_rob_empty,
  input  logic                    i_serialize_commit
`ifdef SERIALIZE_PERF_CNT_EN
  ,
  output logic [31:0]             o_perf_ser_stall
`endif
);

  serCtrlState_t           r_state;
  logic [DW_IDX-1:0]       r_ser_idx;
  logic [DECODE_WIDTH-1:0] r_ser_oh;
  logic [DECODE_WIDTH-1:0] r_ren_vld;
  decInfo_t                r_ren_info [DECODE_WIDTH];

  logic [DECODE_WIDTH-1:0] w_ser_vec;
  logic [DECODE_WIDTH-1:0] w_k_oh;
  logic [DW_IDX-1:0]       w_k_idx;
  logic [DECODE_WIDTH-1:0] w_f_oh;
  logic [DW_IDX-1:0]       w_f_idx;
  logic [DECODE_WIDTH-1:0] w_below_k;
  logic                    w_out_free;
  logic                    w_go_drain;
  logic                    w_ser_still;
  logic                    w_ser_load;
  logic [DECODE_WIDTH-1:0] w_load_mask;

  always_comb begin
    w_ser_vec = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      w_ser_vec[i] = i_dec_info[i].need_serialize;
    end
  end

  ser_first_finder u_finder (
    .i_vld     (i_dec_vld),
    .i_ser     (w_ser_vec),
    .o_k_oh    (w_k_oh),
    .o_k_idx   (w_k_idx),
    .o_f_oh    (w_f_oh),
    .o_f_idx   (w_f_idx),
    .o_below_k (w_below_k)
  );

  assign w_out_free  = !(|r_ren_vld) || i_ren_ready;
  // Serializing inst is the oldest one in the group: split is complete, start draining.
  assign w_go_drain  = (|w_k_oh) && (w_k_idx == w_f_idx);
  // Decode may have flushed the parked inst while we were draining.
  assign w_ser_still = |(i_dec_vld & w_ser_vec & r_ser_oh);

  always_comb begin
    w_load_mask = '0;
    w_ser_load  = 1'b0;
    if (rst && !i_squash) begin
      case (r_state)
        IDLE:    if (w_out_free) w_load_mask = i_dec_vld & w_below_k;
        DRAIN:   w_ser_load = w_ser_still && i_rob_empty && !(|r_ren_vld) && w_out_free;
        default: ;
      endcase
    end
    o_dec_accept = w_load_mask | (w_ser_load ? r_ser_oh : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ser_idx <= '0;
      r_ser_oh  <= '0;
      r_ren_vld <= '0;
      for (int i = 0; i < DECODE_WIDTH; i++) r_ren_info[i] <= '0;
    end else if (i_squash) begin
      r_state   <= IDLE;
      r_ren_vld <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go_drain) begin
            r_state   <= DRAIN;
            r_ser_idx <= w_k_idx;
            r_ser_oh  <= w_f_oh;
          end
        end
        DRAIN: begin
          if (!w_ser_still)    r_state <= IDLE;
          else if (w_ser_load) r_state <= WAIT_CMT;
        end
        WAIT_CMT: begin
          if (i_serialize_commit) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A free register always reloads; slots with nothing to load drop to invalid.
      if (w_out_free) begin
        if (w_ser_load) begin
          r_ren_vld     <= DECODE_WIDTH'(1);
          r_ren_info[0] <= i_dec_info[r_ser_idx];
        end else begin
          r_ren_vld <= w_load_mask;
          for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (w_load_mask[i]) r_ren_info[i] <= i_dec_info[i];
          end
        end
      end
    end
  end

  assign o_ren_vld  = r_ren_vld;
  assign o_ren_info = r_ren_info;

`ifdef SERIALIZE_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  // Counts independently of squash; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_cnt <= '0;
    end else if (r_state == DRAIN || r_state == WAIT_CMT) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign o_perf_ser_stall = r_perf_cnt;
`endif

endmodule

// File: tb/tb_decode_serialize_ctrl.sv
// tb/tb_decode_serialize_ctrl.sv - scoreboard bench for decode_serialize_ctrl
module tb_decode_serialize_ctrl;
  import decode_serialize_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_squash = 1'b0;
  logic [3:0] i_dec_vld = '0;
  decInfo_t   i_dec_info [DECODE_WIDTH];
  logic [3:0] o_dec_accept;
  logic [3:0] o_ren_vld;
  decInfo_t   o_ren_info [DECODE_WIDTH];
  logic       i_ren_ready = 1'b0;
  logic       i_rob_empty = 1'b0;
  logic       i_serialize_commit = 1'b0;
`ifdef SERIALIZE_PERF_CNT_EN
  logic [31:0] o_perf_ser_stall;
`endif

  decode_serialize_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .i_squash           (i_squash),
    .i_dec_vld          (i_dec_vld),
    .i_dec_info         (i_dec_info),
    .o_dec_accept       (o_dec_accept),
    .o_ren_vld          (o_ren_vld),
    .o_ren_info         (o_ren_info),
    .i_ren_ready        (i_ren_ready),
    .i_rob_empty        (i_rob_empty),
    .i_serialize_commit (i_serialize_commit)
`ifdef SERIALIZE_PERF_CNT_EN
    ,
    .o_perf_ser_stall   (o_perf_ser_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]     mask;
    decInfo_t [3:0] info;
  } grp_t;

  int         tests_run = 0;
  int         tests_failed = 0;
  grp_t       exp_q[$];
  grp_t       mon_e;
  logic       mon_en = 1'b0;
  int         ser_taken = 0;
  int         ser_seen = 0;
  logic       ser_out = 1'b0;
  decInfo_t   win_info [4];
  logic [3:0] win_vld = '0;
  logic [3:0] last_ren_vld;
  int         pc_ctr = 0;
  logic [3:0] acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a group splits into runs of plain insts (kept in their slots)
  // and serializing insts (each alone in slot 0), in program order.
  task automatic load_group(input logic [3:0] m, input logic [3:0] sm);
    grp_t g;
    g = '0;
    for (int s = 0; s < 4; s++) begin
      win_info[s] = '0;
      if (m[s]) begin
        win_info[s].pc             = 16'(pc_ctr);
        win_info[s].inst           = $urandom;
        win_info[s].need_serialize = sm[s];
        pc_ctr++;
      end
    end
    win_vld = m;
    for (int s = 0; s < 4; s++) begin
      if (m[s]) begin
        if (sm[s]) begin
          if (g.mask != 4'b0) exp_q.push_back(g);
          g = '0;
          g.mask    = 4'b0001;
          g.info[0] = win_info[s];
          exp_q.push_back(g);
          g = '0;
        end else begin
          g.mask[s] = 1'b1;
          g.info[s] = win_info[s];
        end
      end
    end
    if (g.mask != 4'b0) exp_q.push_back(g);
  endtask

  task automatic step(output logic [3:0] a);
    i_dec_vld = win_vld;
    for (int s = 0; s < 4; s++) i_dec_info[s] = win_info[s];
    @(negedge clk);
    a = o_dec_accept;
    last_ren_vld = o_ren_vld;
    @(posedge clk);
    #1;
    win_vld = win_vld & ~a;
  endtask

  task automatic rstep(input logic force_ready);
    logic [3:0] a;
    logic [3:0] ser_slots;
    logic       was_out;
    logic       cm;
    i_ren_ready = force_ready | (($urandom % 4) != 0);
    i_rob_empty = ($urandom % 3) == 0;
    if (ser_out) cm = (ser_taken > ser_seen) && (($urandom % 2) == 1);
    else         cm = ($urandom % 8) == 0;
    i_serialize_commit = cm;
    was_out = ser_out;
    ser_slots = '0;
    for (int s = 0; s < 4; s++) ser_slots[s] = win_vld[s] & win_info[s].need_serialize;
    step(a);
    if (was_out) begin
      chk("accept_while_waiting", 64'(a), 64'd0);
    end else if ((a & ser_slots) != 4'b0) begin
      chk("ser_accept_alone", 64'($countones(a)), 64'd1);
      chk("ser_needs_empty_backend", {59'd0, i_rob_empty, last_ren_vld}, {59'd0, 1'b1, 4'b0});
      ser_out = 1'b1;
    end
    if (was_out && cm) begin
      ser_out  = 1'b0;
      ser_seen = ser_taken;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst && (o_ren_vld != 4'b0) && i_ren_ready) begin
      if (exp_q.size() == 0) begin
        chk("ren_unexpected_group", 64'(o_ren_vld), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ren_group_mask", 64'(o_ren_vld), 64'(mon_e.mask));
        for (int s = 0; s < 4; s++)
          if (mon_e.mask[s]) chk("ren_group_info", 64'(o_ren_info[s]), 64'(mon_e.info[s]));
        if (mon_e.mask == 4'b0001 && mon_e.info[0].need_serialize) ser_taken++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    for (int s = 0; s < 4; s++) begin
      win_info[s]   = '0;
      i_dec_info[s] = '0;
    end
    // Reset state, with decode already presenting a group.
    i_dec_vld = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ren_vld", 64'(o_ren_vld), 64'd0);
    chk("reset_accept", 64'(o_dec_accept), 64'd0);
`ifdef SERIALIZE_PERF_CNT_EN
    chk("reset_perf", 64'(o_perf_ser_stall), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_dec_vld = 4'b0;
    mon_en = 1'b1;
    i_ren_ready = 1'b1;

`ifdef SERIALIZE_PERF_CNT_EN
    // 3 DRAIN cycles + 2 WAIT_CMT cycles.
    load_group(4'b0001, 4'b0001);
    i_rob_empty = 1'b0;
    step(acc); chk("perf_enter_drain", 64'(acc), 64'd0);
    step(acc);
    step(acc);
    i_rob_empty = 1'b1;
    step(acc); chk("perf_ser_issue", 64'(acc), 64'b0001);
    i_rob_empty = 1'b0;
    step(acc);
    i_serialize_commit = 1'b1;
    step(acc);
    i_serialize_commit = 1'b0;
    chk("perf_count_5", 64'(o_perf_ser_stall), 64'd5);
`endif

    // Plain full group passes straight through.
    load_group(4'b1111, 4'b0000);
    step(acc); chk("t1_accept_all", 64'(acc), 64'b1111);
    step(acc);

    // Output held while rename stalls.
    load_group(4'b0011, 4'b0000);
    step(acc); chk("t3_accept_first", 64'(acc), 64'b0011);
    i_ren_ready = 1'b0;
    load_group(4'b1111, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(acc);
      chk("t3_hold_accept", 64'(acc), 64'd0);
      chk("t3_hold_ren_vld", 64'(last_ren_vld), 64'b0011);
    end
    i_ren_ready = 1'b1;
    step(acc); chk("t3_release_accept", 64'(acc), 64'b1111);
    step(acc);

    // Serialize in slot 2: split, drain, issue alone, wait for commit.
    i_rob_empty = 1'b0;
    load_group(4'b1111, 4'b0100);
    step(acc); chk("t2_split", 64'(acc), 64'b0011);
    step(acc); chk("t2_to_drain", 64'(acc), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(acc);
      chk("t2_drain_wait", 64'(acc), 64'd0);
    end
    i_rob_empty = 1'b1;
    step(acc); chk("t2_ser_issue", 64'(acc), 64'b0100);
    i_rob_empty = 1'b0;
    step(acc); chk("t2_wait_cmt", 64'(acc), 64'd0);
    i_serialize_commit = 1'b1;
    step(acc); chk("t2_commit_cycle", 64'(acc), 64'd0);
    i_serialize_commit = 1'b0;
    step(acc); chk("t2_after_commit", 64'(acc), 64'b1000);
    step(acc);
    chk("directed_queue_empty", 64'(exp_q.size()), 64'd0);

    // Squash and commit together in WAIT_CMT.
    mon_en = 1'b0;
    i_ren_ready = 1'b0;
    i_rob_empty = 1'b1;
    load_group(4'b0001, 4'b0001);
    step(acc);
    step(acc); chk("t4_ser_issue", 64'(acc), 64'b0001);
    load_group(4'b0011, 4'b0000);
    i_squash = 1'b1;
    i_serialize_commit = 1'b1;
    step(acc); chk("t4_squash_no_accept", 64'(acc), 64'd0);
    i_squash = 1'b0;
    i_serialize_commit = 1'b0;
    step(acc);
    chk("t4_squash_clears_out", 64'(last_ren_vld), 64'd0);
    chk("t4_idle_accept", 64'(acc), 64'b0011);
    i_ren_ready = 1'b1;
    step(acc);

    // Asynchronous reset while in DRAIN.
    i_ren_ready = 1'b0;
    i_rob_empty = 1'b0;
    load_group(4'b1111, 4'b0100);
    step(acc); chk("t5_split", 64'(acc), 64'b0011);
    step(acc);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_clear", 64'(o_ren_vld), 64'd0);
`ifdef SERIALIZE_PERF_CNT_EN
    chk("t5_perf_cleared", 64'(o_perf_ser_stall), 64'd0);
`endif
    rst = 1'b1;
    i_rob_empty = 1'b1;
    step(acc); chk("t5_back_in_idle", 64'(acc), 64'd0);
    step(acc); chk("t5_drain_issue", 64'(acc), 64'b0100);
    i_ren_ready = 1'b1;
    i_serialize_commit = 1'b1;
    step(acc);
    i_serialize_commit = 1'b0;
    step(acc); chk("t5_tail", 64'(acc), 64'b1000);
    step(acc);
    exp_q.delete();

    // Randomized traffic against the reference model.
    mon_en = 1'b1;
    ser_out = 1'b0;
    ser_seen = ser_taken;
    for (int g = 0; g < 150; g++) begin
      load_group(4'($urandom_range(1, 15)), (($urandom % 3) == 0) ? 4'($urandom) : 4'b0);
      budget = 0;
      while (win_vld != 4'b0 && budget < 300) begin
        rstep(1'b0);
        budget++;
      end
      chk("group_consumed", 64'(win_vld), 64'd0);
    end
    budget = 0;
    while ((exp_q.size() != 0 || ser_out) && budget < 300) begin
      rstep(1'b1);
      budget++;
    end
    i_serialize_commit = 1'b0;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
